// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB TX path: the packet command encoding seen by
// the TX control FSM, the scheduler state encoding, the counter width and the
// default inter-packet gap / watchdog limits.
// ---------------------------------------------------------------------------
package usb_pkg;

  // Packet command handed to the TX control FSM
  typedef enum logic [1:0] {
    PKT_IDLE = 2'b00,
    PKT_DATA = 2'b01,
    PKT_ACK  = 2'b10,
    PKT_NACK = 2'b11
  } tx_packet_t;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_EOP = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_t;

  localparam int CNT_BITS           = 10;
  localparam int DEFAULT_GAP_CYCLES = 16;
  localparam int DEFAULT_WDOG_LIMIT = 1023;

  // Handshake packets carry no payload and no size
  function automatic logic is_handshake(input tx_packet_t pkt);
    return (pkt == PKT_ACK) || (pkt == PKT_NACK);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Free-running up counter with synchronous clear (priority over enable).
// Ports:
//   clk          in   system clock
//   n_rst        in   asynchronous active-low reset
//   clear        in   synchronous clear to zero
//   count_enable in   increment when high
//   count_out    out  current count (NUM_CNT_BITS wide)
// ---------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 10
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_reg;
  logic [NUM_CNT_BITS-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_out = count_reg;

endmodule

// File: rtl/tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tx_packet_scheduler
// Decides which packet the TX control FSM sends next. ACK/NACK requests from
// RX are latched into pending flags and take priority over DATA; NACK beats
// ACK when both are pending. After each packet an idle gap of GAP_CYCLES is
// enforced, and a watchdog aborts a packet whose tx_eop never arrives.
// Ports:
//   clk                  in   system clock
//   n_rst                in   asynchronous active-low reset
//   ack_req              in   pulse: RX wants an ACK sent
//   nack_req             in   pulse: RX wants a NACK sent
//   data_req             in   level: TX buffer holds a packet
//   data_size[6:0]       in   byte count of that packet
//   tx_eop               in   pulse: TX control FSM finished the packet
//   tx_packet[1:0]       out  command: 00 IDLE, 01 DATA, 10 ACK, 11 NACK
//   tx_packet_data_size  out  size latched at DATA issue
//   tx_busy              out  high from issue until the gap completes
//   tx_done              out  one-cycle pulse when a DATA packet ends
//   tx_timeout           out  sticky watchdog-expired flag
// ---------------------------------------------------------------------------
module tx_packet_scheduler
  import usb_pkg::*;
#(
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int WDOG_LIMIT = DEFAULT_WDOG_LIMIT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ack_req,
  input  logic       nack_req,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic       tx_eop,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_data_size,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_timeout
);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle interval sees count == N-1.
  localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(GAP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] WDOG_LAST = CNT_BITS'(WDOG_LIMIT - 1);

  sched_state_t  state_reg, state_next;
  tx_packet_t    pkt_reg, pkt_next;
  logic [6:0]    size_reg, size_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          timeout_reg, timeout_next;
  logic          ack_pend_reg, ack_pend_next;
  logic          nack_pend_reg, nack_pend_next;

  logic [CNT_BITS-1:0] count;
  logic                count_clear;
  logic                count_enable;

  // One counter serves both the watchdog and the gap; every state change
  // restarts it from zero.
  assign count_clear  = (state_next != state_reg);
  assign count_enable = (state_reg == ST_WAIT_EOP) || (state_reg == ST_GAP);

  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (count_clear),
    .count_enable(count_enable),
    .count_out   (count)
  );

  always_comb begin
    state_next     = state_reg;
    pkt_next       = pkt_reg;
    size_next      = size_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    timeout_next   = timeout_reg;
    // Incoming pulses are captured in every state
    ack_pend_next  = ack_pend_reg | ack_req;
    nack_pend_next = nack_pend_reg | nack_req;

    case (state_reg)
      ST_IDLE: begin
        if (nack_pend_reg || ack_pend_reg) begin
          pkt_next = nack_pend_reg ? PKT_NACK : PKT_ACK;
          // A handshake consumes both flags; a pulse arriving in this very
          // cycle survives as a new pending request.
          ack_pend_next  = ack_req;
          nack_pend_next = nack_req;
        end else if (data_req) begin
          pkt_next  = PKT_DATA;
          size_next = data_size;
        end
        if (nack_pend_reg || ack_pend_reg || data_req) begin
          state_next = ST_ISSUE;
          busy_next  = 1'b1;
        end
      end

      ST_ISSUE: begin
        state_next = ST_WAIT_EOP;
      end

      ST_WAIT_EOP: begin
        // A tx_eop that coincides with watchdog expiry is a normal finish
        if (tx_eop) begin
          state_next = ST_GAP;
          pkt_next   = PKT_IDLE;
          done_next  = !is_handshake(pkt_reg) && (pkt_reg == PKT_DATA);
        end else if (count == WDOG_LAST) begin
          state_next   = ST_GAP;
          pkt_next     = PKT_IDLE;
          timeout_next = 1'b1;
        end
      end

      ST_GAP: begin
        if (count == GAP_LAST) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
        pkt_next   = PKT_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= ST_IDLE;
      pkt_reg       <= PKT_IDLE;
      size_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      ack_pend_reg  <= 1'b0;
      nack_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pkt_reg       <= pkt_next;
      size_reg      <= size_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
      ack_pend_reg  <= ack_pend_next;
      nack_pend_reg <= nack_pend_next;
    end
  end

  assign tx_packet           = pkt_reg;
  assign tx_packet_data_size = size_reg;
  assign tx_busy             = busy_reg;
  assign tx_done             = done_reg;
  assign tx_timeout          = timeout_reg;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_scheduler
// Directed bench for tx_packet_scheduler (GAP_CYCLES=16, WDOG_LIMIT=1023).
// Inputs change 1 ns after the rising edge; outputs are sampled at that
// same point, so each tick() advances exactly one clock.
// ---------------------------------------------------------------------------
module tb_tx_packet_scheduler;

  logic       clk;
  logic       n_rst;
  logic       ack_req;
  logic       nack_req;
  logic       data_req;
  logic [6:0] data_size;
  logic       tx_eop;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_timeout;

  int checks = 0;
  int errors = 0;

  tx_packet_scheduler dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .ack_req            (ack_req),
    .nack_req           (nack_req),
    .data_req           (data_req),
    .data_size          (data_size),
    .tx_eop             (tx_eop),
    .tx_packet          (tx_packet),
    .tx_packet_data_size(tx_packet_data_size),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_timeout         (tx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise tx_eop for one cycle, then let the 16-cycle gap run out.
  task automatic finish_packet_and_gap();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    repeat (16) tick();
  endtask

  initial begin
    n_rst = 1'b0; ack_req = 1'b0; nack_req = 1'b0;
    data_req = 1'b0; data_size = 7'd0; tx_eop = 1'b0;
    repeat (3) tick();
    check("rst_pkt",     32'(tx_packet), 32'd0);
    check("rst_size",    32'(tx_packet_data_size), 32'd0);
    check("rst_busy",    32'(tx_busy), 32'd0);
    check("rst_done",    32'(tx_done), 32'd0);
    check("rst_timeout", 32'(tx_timeout), 32'd0);
    n_rst = 1'b1;
    tick();

    // ---- DATA size 8, normal end ----
    data_req = 1'b1; data_size = 7'd8;
    tick();
    check("d8_pkt",  32'(tx_packet), 32'h1);
    check("d8_size", 32'(tx_packet_data_size), 32'd8);
    check("d8_busy", 32'(tx_busy), 32'd1);
    data_req = 1'b0;
    tick();
    check("d8_hold", 32'(tx_packet), 32'h1);
    tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("d8_done",     32'(tx_done), 32'd1);
    check("d8_pkt_idle", 32'(tx_packet), 32'h0);
    check("d8_busy_gap", 32'(tx_busy), 32'd1);
    tick();
    check("d8_done_one", 32'(tx_done), 32'd0);
    repeat (14) tick();
    check("d8_busy_g15", 32'(tx_busy), 32'd1);
    tick();
    check("d8_busy_g16", 32'(tx_busy), 32'd0);
    // stray tx_eop in IDLE
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("stray_pkt",  32'(tx_packet), 32'h0);
    check("stray_busy", 32'(tx_busy), 32'd0);
    check("stray_done", 32'(tx_done), 32'd0);
    $display("txn 1: DATA size 8 + stray eop");

    // ---- ACK pending together with data_req: ACK first, then DATA ----
    ack_req = 1'b1;
    tick();
    ack_req = 1'b0; data_req = 1'b1; data_size = 7'd5;
    tick();
    check("ack_first",     32'(tx_packet), 32'h2);
    check("ack_size_keep", 32'(tx_packet_data_size), 32'd8);
    tick();
    tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("ack_no_done", 32'(tx_done), 32'd0);
    check("ack_end_pkt", 32'(tx_packet), 32'h0);
    repeat (16) tick();
    check("ack_gap_pkt",  32'(tx_packet), 32'h0);
    check("ack_gap_busy", 32'(tx_busy), 32'd0);
    tick();
    check("data_after_ack", 32'(tx_packet), 32'h1);
    check("data5_size",     32'(tx_packet_data_size), 32'd5);
    data_req = 1'b0;
    tick();
    tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("data5_done", 32'(tx_done), 32'd1);
    repeat (16) tick();
    check("data5_idle", 32'(tx_busy), 32'd0);
    $display("txn 2: ACK then DATA size 5");

    // ---- ACK and NACK together: single NACK ----
    ack_req = 1'b1; nack_req = 1'b1;
    tick();
    ack_req = 1'b0; nack_req = 1'b0;
    tick();
    check("both_nack", 32'(tx_packet), 32'h3);
    tick();
    tick();
    finish_packet_and_gap();
    repeat (3) tick();
    check("both_no_ack_pkt",  32'(tx_packet), 32'h0);
    check("both_no_ack_busy", 32'(tx_busy), 32'd0);
    $display("txn 3: ACK+NACK -> one NACK");

    // ---- ACK pulse in the cycle NACK is issued stays pending ----
    nack_req = 1'b1;
    tick();
    nack_req = 1'b0; ack_req = 1'b1;
    tick();
    ack_req = 1'b0;
    check("setwin_nack", 32'(tx_packet), 32'h3);
    tick();
    tick();
    finish_packet_and_gap();
    tick();
    check("setwin_ack", 32'(tx_packet), 32'h2);
    tick();
    tick();
    finish_packet_and_gap();
    $display("txn 4: NACK then retained ACK");

    // ---- DATA size 0, eop during ISSUE ignored, ACK during gap ----
    data_req = 1'b1; data_size = 7'd0;
    tick();
    check("d0_pkt",  32'(tx_packet), 32'h1);
    check("d0_size", 32'(tx_packet_data_size), 32'd0);
    data_req = 1'b0; tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("d0_eop_issue_ignored", 32'(tx_packet), 32'h1);
    check("d0_eop_issue_nodone",  32'(tx_done), 32'd0);
    tick();
    tx_eop = 1'b1;
    tick();
    tx_eop = 1'b0;
    check("d0_done", 32'(tx_done), 32'd1);
    repeat (5) tick();
    ack_req = 1'b1;
    tick();
    ack_req = 1'b0;
    repeat (9) tick();
    check("gapack_busy15", 32'(tx_busy), 32'd1);
    check("gapack_pkt15",  32'(tx_packet), 32'h0);
    tick();
    check("gapack_busy16", 32'(tx_busy), 32'd0);
    check("gapack_pkt16",  32'(tx_packet), 32'h0);
    tick();
    check("gapack_issue", 32'(tx_packet), 32'h2);
    tick();
    tick();
    finish_packet_and_gap();
    $display("txn 5: DATA size 0, ACK during gap");

    // ---- watchdog ----
    data_req = 1'b1; data_size = 7'd9;
    tick();
    check("wd_pkt", 32'(tx_packet), 32'h1);
    data_req = 1'b0;
    repeat (1023) tick();
    check("wd_not_yet",     32'(tx_timeout), 32'd0);
    check("wd_pkt_held",    32'(tx_packet), 32'h1);
    tick();
    check("wd_timeout",     32'(tx_timeout), 32'd1);
    check("wd_pkt_idle",    32'(tx_packet), 32'h0);
    check("wd_no_done",     32'(tx_done), 32'd0);
    check("wd_busy_gap",    32'(tx_busy), 32'd1);
    repeat (16) tick();
    check("wd_idle_busy",   32'(tx_busy), 32'd0);
    tick();
    check("wd_sticky",      32'(tx_timeout), 32'd1);
    check("wd_idle_pkt",    32'(tx_packet), 32'h0);
    $display("txn 6: watchdog expiry");

    // ---- reset in WAIT_EOP with NACK pending ----
    data_req = 1'b1; data_size = 7'd3;
    tick();
    data_req = 1'b0;
    tick();
    nack_req = 1'b1;
    tick();
    nack_req = 1'b0;
    check("rst2_pre_pkt", 32'(tx_packet), 32'h1);
    n_rst = 1'b0;
    #1;
    check("rst2_pkt",     32'(tx_packet), 32'h0);
    check("rst2_size",    32'(tx_packet_data_size), 32'd0);
    check("rst2_busy",    32'(tx_busy), 32'd0);
    check("rst2_done",    32'(tx_done), 32'd0);
    check("rst2_timeout", 32'(tx_timeout), 32'd0);
    tick();
    n_rst = 1'b1;
    repeat (5) tick();
    check("rst2_no_issue_pkt",  32'(tx_packet), 32'h0);
    check("rst2_no_issue_busy", 32'(tx_busy), 32'd0);
    $display("txn 7: reset mid-packet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_packet_scheduler.md
TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, idle bit-times enforced between consecutive packets.
REQ-002 SHALL have parameter WDOG_LIMIT, default 1023, maximum cycles allowed from issue to tx_eop.
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ack_req  in  1  single-cycle pulse from RX requesting an ACK handshake.
REQ-006 SHALL have port nack_req  in  1  single-cycle pulse from RX requesting a NACK handshake.
REQ-007 SHALL have port data_req  in  1  level from AHB side: TX buffer holds a packet ready to send.
REQ-008 SHALL have port data_size  in  7  byte count of the pending data packet.
REQ-009 SHALL have port tx_eop  in  1  pulse from the TX control FSM marking end of packet.
REQ-010 SHALL have port tx_packet  out  2  packet command to TX: 00 IDLE, 01 DATA, 10 ACK, 11 NACK.
REQ-011 SHALL have port tx_packet_data_size  out  7  latched size for the issued DATA packet.
REQ-012 SHALL have port tx_busy  out  1  high from issue until GAP completes.
REQ-013 SHALL have port tx_done  out  1  one-cycle pulse when the DATA packet ends (tx_eop).
REQ-014 SHALL have port tx_timeout  out  1  sticky flag, set on watchdog expiry.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_EOP, GAP; all outputs registered.
REQ-016 SHALL latch ack_req/nack_req pulses into pending flags in any state; pulses are never lost.
REQ-017 SHALL, when both ACK and NACK are pending, issue NACK and clear both flags at issue.
REQ-018 SHALL give handshakes (ACK/NACK) priority over DATA when both are eligible in IDLE.
REQ-019 IDLE -> ISSUE when any pending flag or data_req is high; next cycle tx_packet SHALL equal the chosen code (latency 1).
REQ-020 SHALL latch data_size into tx_packet_data_size on DATA issue; it stays stable until the next DATA issue; size 0 is passed through unchanged.
REQ-021 ISSUE -> WAIT_EOP after one cycle; tx_packet SHALL hold the issued code, unchanged, throughout ISSUE and WAIT_EOP.
REQ-022 WAIT_EOP -> GAP on tx_eop; tx_packet SHALL return to 00 the cycle after tx_eop.
REQ-023 SHALL pulse tx_done for exactly one cycle, the cycle after tx_eop, only when the packet was DATA.
REQ-024 SHALL count cycles in WAIT_EOP; at WDOG_LIMIT without tx_eop it SHALL set tx_timeout, drive tx_packet 00, and go to GAP; no tx_done.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; requests arriving during GAP are held pending.
REQ-026 tx_eop outside WAIT_EOP SHALL be ignored.
REQ-027 tx_timeout SHALL clear only on reset.
REQ-028 The ack_req/nack_req pulse in the same cycle the flags are cleared at issue SHALL remain pending (set wins).

Reset
REQ-029 On n_rst low: state IDLE, tx_packet 00, tx_packet_data_size 0, tx_busy 0, tx_done 0, tx_timeout 0, pending flags and counters 0.
REQ-030 Reset mid-packet SHALL immediately force tx_packet 00 and discard all pending requests.

Structure
REQ-031 The tx_packet encoding (tx_packet_t) and the default GAP_CYCLES/WDOG_LIMIT SHALL live in shared package usb_pkg, used by this block and the TX control FSM.
REQ-032 SHALL instantiate one flex_counter (10-bit) shared by GAP and watchdog counting, cleared on each state entry.

Verification
REQ-033 data_req=1, data_size=8 in IDLE -> tx_packet=01 and size=8 one cycle later; tx_eop -> tx_done pulse, tx_packet=00, tx_busy low after 16 cycles.
REQ-034 ack_req pulse while data_req=1 -> ACK (10) issued first; after EOP plus 16-cycle gap, DATA (01) issued.
REQ-035 ack_req and nack_req pulse in the same cycle -> NACK (11) issued once, no ACK follows.
REQ-036 DATA issued, no tx_eop for 1023 cycles -> tx_timeout=1, tx_packet=00, no tx_done, IDLE after gap.
REQ-037 ack_req during GAP -> ACK issued the cycle after GAP ends; stray tx_eop in IDLE -> no change.
REQ-038 n_rst asserted in WAIT_EOP with NACK pending -> all outputs 0; no packet issued after release.
